bus_cycle_unit: RTL and testbench
=================================

BUS_CYCLE_UNIT -- requirements
Module: bus_cycle_unit

Interface
REQ-001 Parameters SHALL be: AW, 16, total address width; DW, 8, data width, multiplexed on the low address lines (DW < AW); WAIT_W, 4, wait counter width, giving MAX_WAIT = 2^WAIT_W-1.
REQ-002 Ports SHALL be, clock and reset first:
- phi1  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  core requests a machine cycle.
- req_we  in  1  1=write, 0=read.
- req_io  in  1  1=I/O, 0=memory.
- req_fetch  in  1  opcode fetch (read only).
- req_addr  in  AW  cycle address.
- req_wdata  in  DW  write data.
- req_ack  out  1  one-cycle pulse: request accepted.
- rdata  out  DW  read data.
- rdata_valid  out  1  one-cycle pulse: rdata updated.
- timeout  out  1  one-cycle pulse: wait limit hit.
- haddress  out  AW-DW  high address.
- ad_out  out  DW  address/data drive value.
- ad_oe  out  1  enable for the tristate ad lines (tristate lives in top).
- ad_in  in  DW  sampled ad lines.
- ale  out  1  address latch enable.
- rd_n, wr_n  out  1 each  active-low strobes.
- iom_n, s0, s1  out  1 each  cycle status.
- ready  in  1  slave ready; low inserts waits.
- hold  in  1  external bus request.
- hlda  out  1  hold acknowledge.
- bus_float  out  1  top SHALL tristate haddress, strobes and status while this is high.

Function
REQ-003 The FSM SHALL have states IDLE, T1, T2, TW, T3 and HOLD.
REQ-004 In IDLE with req=1 and hold=0, the block SHALL pulse req_ack, latch addr, wdata and type, and enter T1 on the next edge.
REQ-005 In IDLE with hold=1, the block SHALL enter HOLD; hold SHALL win over a simultaneous req, which stays pending and unacknowledged.
REQ-006 In T1 the block SHALL drive: ale=1, ad_oe=1, ad_out=addr[DW-1:0], haddress=addr[AW-1:DW], and iom_n=req_io.
REQ-007 The s1/s0 encoding SHALL be: fetch 11, read 10, write 01, idle/hold 00.
- Status SHALL be held from T1 through T3.
- haddress SHALL be held from T1 through T3.
REQ-008 In T2, TW and T3 ale SHALL be 0.
- Read: rd_n=0 and ad_oe=0.
- Write: wr_n=0, ad_oe=1 and ad_out=wdata.
REQ-009 ready SHALL be sampled at the end of T2 and of each TW: ready=1 goes to T3, ready=0 goes to (or stays in) TW.
REQ-010 The wait counter SHALL clear in T1 and increment per TW cycle; reaching MAX_WAIT SHALL force T3 and pulse timeout in that T3 cycle.
REQ-011 On a read, ad_in SHALL be captured into rdata at the edge ending T3, with rdata_valid=1 during the following cycle.
REQ-012 Strobes SHALL return inactive at the edge ending T3; T3 SHALL never be skipped.
REQ-013 Zero-wait latency SHALL be: accept cycle, T1, T2, T3, then rdata_valid (4 cycles after accept).
REQ-014 Exit from T3 SHALL be decided in this order:
- hold=1: go to HOLD.
- req=1: pulse req_ack and go directly to T1 (back-to-back, no IDLE).
- Otherwise: go to IDLE.
REQ-015 hold SHALL be ignored in T1, T2 and TW.
REQ-016 In HOLD, hlda=1, bus_float=1 and ad_oe=0; hold=0 SHALL return the FSM to IDLE on the next edge, with hlda low in IDLE.
REQ-017 req changing after req_ack SHALL have no effect on the cycle in flight.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE with these output values:
- ale=0, ad_oe=0, rd_n=1, wr_n=1.
- iom_n=0, s0=0, s1=0.
- hlda=0, bus_float=0.
- req_ack=0, rdata_valid=0, timeout=0.
- rdata=0, wait counter=0, haddress=0, ad_out=0.
REQ-019 Reset asserted mid-cycle SHALL abort the cycle: no rdata_valid and no further ack.

Structure
REQ-020 Package bus_pkg SHALL hold the FSM state enum and the s1/s0 status constants (ST_FETCH, ST_READ, ST_WRITE, ST_IDLE).
REQ-021 Sub-module wait_timer (WAIT_W counter with clear, increment and terminal flag) SHALL be the only sub-module.

Verification
REQ-022 Directed scenarios:
- Memory read: addr 0x12A4, ready=1, ad_in=0x5C; expect ale pulse with ad_out=0xA4 and haddress=0x12, s1s0=10, iom_n=0, rd_n low 2 cycles, rdata=0x5C with rdata_valid 4 cycles after req_ack.
- I/O write: addr 0x0033, data 0xE7, ready low 3 cycles; expect 3 TW cycles, wr_n low 5 cycles, ad_out=0xE7 with ad_oe=1, iom_n=1, s1s0=01.
- Timeout: WAIT_W=2, ready held 0; expect exactly 3 TW cycles, then T3 with a timeout pulse.
- Back-to-back: fetch then read with req held; expect T3 followed directly by T1 and two req_ack pulses 3 cycles apart.
- Hold: hold raised during T2; expect the cycle to complete, then hlda=1 and bus_float=1; hold and req raised together in IDLE give HOLD first, with T1 after hold drops.
- Reset during TW: expect immediate IDLE values, rd_n=1, and no rdata_valid.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the bus cycle unit: FSM states, cycle type and status codes.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    HOLD
  } bus_state_t;

  // s1/s0 status codes driven for the whole T1..T3 window
  localparam logic [1:0] ST_FETCH = 2'b11;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_IDLE  = 2'b00;

  // Latched type of the cycle in flight; fetch is always a read
  typedef struct packed {
    logic we;
    logic io;
    logic fetch;
  } cyc_type_t;

  function automatic logic [1:0] status_of(cyc_type_t t);
    if (t.fetch) return ST_FETCH;
    if (t.we)    return ST_WRITE;
    return ST_READ;
  endfunction

endpackage

// File: rtl/bus_cycle_unit_wait_timer.sv
// Wait-state counter: cleared at cycle start, bumped once per wait state.
// term flags that the increment happening now brings the count to MAX_WAIT.
module wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic phi1,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [WAIT_W-1:0] MAX_WAIT = '1;

  logic [WAIT_W-1:0] count;

  // count wait cycles, saturating at MAX_WAIT
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst)                          count <= '0;
    else if (clr)                     count <= '0;
    else if (inc && count != MAX_WAIT) count <= count + 1'b1;
  end

  assign term = (count == MAX_WAIT - 1'b1);

endmodule

// File: rtl/bus_cycle_unit.sv
// Multiplexed address/data bus cycle engine: T1/T2/TW/T3 machine cycles,
// ready-driven wait states with a timeout, and hold/hlda bus handover.
module bus_cycle_unit
  import bus_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int WAIT_W = 4
) (
  input  logic             phi1,
  input  logic             rst,
  input  logic             req,
  input  logic             req_we,
  input  logic             req_io,
  input  logic             req_fetch,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic             req_ack,
  output logic [DW-1:0]    rdata,
  output logic             rdata_valid,
  output logic             timeout,
  output logic [AW-DW-1:0] haddress,
  output logic [DW-1:0]    ad_out,
  output logic             ad_oe,
  input  logic [DW-1:0]    ad_in,
  output logic             ale,
  output logic             rd_n,
  output logic             wr_n,
  output logic             iom_n,
  output logic             s0,
  output logic             s1,
  input  logic             ready,
  input  logic             hold,
  output logic             hlda,
  output logic             bus_float
);

  bus_state_t      state, state_nx;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  cyc_type_t       typ_q;
  cyc_type_t       req_typ;
  logic            accept;
  logic            tmo_set;
  logic            wterm;
  logic            in_bus;
  logic            data_ph;

  assign req_typ = '{we: req_we & ~req_fetch, io: req_io, fetch: req_fetch};

  wait_timer #(.WAIT_W(WAIT_W)) u_wait (
    .phi1 (phi1),
    .rst  (rst),
    .clr  (state == T1),
    .inc  (state == TW),
    .term (wterm)
  );

  // next state; hold is only looked at in IDLE, T3 and HOLD
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    tmo_set  = 1'b0;
    case (state)
      IDLE: begin
        if (hold)     state_nx = HOLD;
        else if (req) begin accept = 1'b1; state_nx = T1; end
      end
      T1:   state_nx = T2;
      T2:   state_nx = ready ? T3 : TW;
      TW: begin
        if (ready)      state_nx = T3;
        else if (wterm) begin state_nx = T3; tmo_set = 1'b1; end
      end
      T3: begin
        if (hold)     state_nx = HOLD;
        else if (req) begin accept = 1'b1; state_nx = T1; end
        else          state_nx = IDLE;
      end
      HOLD: if (!hold) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ack is combinational with the accept decision; masked while in reset
  assign req_ack = accept & ~rst;

  // state register and per-cycle request latch
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      typ_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        typ_q   <= req_typ;
      end
    end
  end

  // read data captured at the edge that ends T3, flagged for one cycle
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= (state == T3) && !typ_q.we;
      if ((state == T3) && !typ_q.we) rdata <= ad_in;
    end
  end

  // timeout pulse lands in the forced T3 cycle
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= tmo_set;
  end

  // bus pin values decoded from state and the latched cycle type
  always_comb begin
    in_bus    = (state == T1) || (state == T2) || (state == TW) || (state == T3);
    data_ph   = (state == T2) || (state == TW) || (state == T3);
    ale       = (state == T1);
    haddress  = in_bus ? addr_q[AW-1:DW] : '0;
    iom_n     = in_bus & typ_q.io;
    {s1, s0}  = in_bus ? status_of(typ_q) : ST_IDLE;
    rd_n      = !(data_ph && !typ_q.we);
    wr_n      = !(data_ph && typ_q.we);
    ad_oe     = (state == T1) || (data_ph && typ_q.we);
    ad_out    = '0;
    if (state == T1)               ad_out = addr_q[DW-1:0];
    else if (data_ph && typ_q.we)  ad_out = wdata_q;
    hlda      = (state == HOLD);
    bus_float = (state == HOLD);
  end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Directed bench for bus_cycle_unit with a cycle-level behavioural model.
module tb_bus_cycle_unit;

  localparam int MAXW = 3;  // WAIT_W = 2

  logic        phi1 = 1'b0;
  logic        rst, req, req_we, req_io, req_fetch, ready, hold;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, ad_in;
  logic        req_ack, rdata_valid, timeout, ad_oe, ale, rd_n, wr_n, iom_n, s0, s1, hlda, bus_float;
  logic [7:0]  rdata, haddress, ad_out;

  bus_cycle_unit #(.AW(16), .DW(8), .WAIT_W(2)) dut (
    .phi1(phi1), .rst(rst), .req(req), .req_we(req_we), .req_io(req_io),
    .req_fetch(req_fetch), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rdata(rdata), .rdata_valid(rdata_valid), .timeout(timeout),
    .haddress(haddress), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ale(ale),
    .rd_n(rd_n), .wr_n(wr_n), .iom_n(iom_n), .s0(s0), .s1(s1), .ready(ready),
    .hold(hold), .hlda(hlda), .bus_float(bus_float)
  );

  always #5 phi1 = ~phi1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running a machine cycle, 2 bus handed over
  int         m_mode = 0;
  int         m_pos = 0;     // cycles since T1 of the current machine cycle
  int         m_waits = 0;   // wait states inserted so far
  bit         m_t3 = 0;      // current cycle is the final one
  bit         m_we = 0, m_io = 0, m_fetch = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, m_rdata = '0;
  bit         m_rv = 0, m_tmo = 0;

  function automatic void m_start();
    m_mode = 1; m_pos = 0; m_waits = 0; m_t3 = 0;
    m_we = req_we && !req_fetch; m_io = req_io; m_fetch = req_fetch;
    m_addr = req_addr; m_wdata = req_wdata;
  endfunction

  always @(posedge phi1 or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_waits = 0; m_t3 = 0; m_we = 0; m_io = 0; m_fetch = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_rv = 0; m_tmo = 0;
    end else begin
      m_rv = 0; m_tmo = 0;
      if (m_mode == 0) begin
        if (hold) m_mode = 2;
        else if (req) m_start();
      end else if (m_mode == 2) begin
        if (!hold) m_mode = 0;
      end else if (m_t3) begin
        if (!m_we) begin m_rv = 1; m_rdata = ad_in; end
        if (hold) m_mode = 2;
        else if (req) m_start();
        else m_mode = 0;
      end else begin
        if (m_pos >= 1) begin
          if (ready) m_t3 = 1;
          else if (m_waits == MAXW) begin m_t3 = 1; m_tmo = 1; end
          else m_waits++;
        end
        m_pos++;
      end
    end
  end

  // ---------------- monitor + per-cycle compare ----------------
  int         cyc = 0;
  int         ack_cyc[$], rv_cyc[$], ale_cyc[$], tmo_cyc[$];
  logic [7:0] ale_lo[$], ale_hi[$], rv_data[$];
  logic [1:0] ale_st[$];
  logic       ale_io[$];
  int         rd_low = 0, wr_low = 0, wr_good = 0;

  always @(negedge phi1) begin
    bit         in_bus, t1, dp, e_ack;
    logic [7:0] e_ado;
    logic [1:0] e_st;
    in_bus = (m_mode == 1);
    t1     = in_bus && (m_pos == 0);
    dp     = in_bus && (m_pos > 0);
    e_ack  = !rst && req && !hold && ((m_mode == 0) || (in_bus && m_t3));
    e_ado  = t1 ? m_addr[7:0] : ((dp && m_we) ? m_wdata : 8'h00);
    e_st   = !in_bus ? 2'b00 : (m_fetch ? 2'b11 : (m_we ? 2'b01 : 2'b10));
    chk("req_ack", req_ack, e_ack);
    chk("ale", ale, t1);
    chk("ad_oe", ad_oe, t1 || (dp && m_we));
    chk("ad_out", ad_out, e_ado);
    chk("haddress", haddress, in_bus ? m_addr[15:8] : 8'h00);
    chk("rd_n", rd_n, !(dp && !m_we));
    chk("wr_n", wr_n, !(dp && m_we));
    chk("iom_n", iom_n, in_bus && m_io);
    chk("s1s0", {s1, s0}, e_st);
    chk("hlda", hlda, m_mode == 2);
    chk("bus_float", bus_float, m_mode == 2);
    chk("rdata", rdata, m_rdata);
    chk("rdata_valid", rdata_valid, m_rv);
    chk("timeout", timeout, m_tmo);

    cyc++;
    if (req_ack) ack_cyc.push_back(cyc);
    if (rdata_valid) begin rv_cyc.push_back(cyc); rv_data.push_back(rdata); end
    if (timeout) tmo_cyc.push_back(cyc);
    if (ale) begin
      ale_cyc.push_back(cyc); ale_lo.push_back(ad_out); ale_hi.push_back(haddress);
      ale_st.push_back({s1, s0}); ale_io.push_back(iom_n);
    end
    if (!rd_n) rd_low++;
    if (!wr_n) wr_low++;
    if (!wr_n && ad_oe && ad_out == 8'hE7) wr_good++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge phi1); #1; end
  endtask

  task automatic clr_mon();
    ack_cyc.delete(); rv_cyc.delete(); ale_cyc.delete(); tmo_cyc.delete();
    ale_lo.delete(); ale_hi.delete(); rv_data.delete(); ale_st.delete(); ale_io.delete();
    rd_low = 0; wr_low = 0; wr_good = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1; req = 0; req_we = 0; req_io = 0; req_fetch = 0; hold = 0; ready = 1;
    req_addr = '0; req_wdata = '0; ad_in = '0;
    tick(2);
    chk("rst_ale", ale, 0); chk("rst_rd_n", rd_n, 1); chk("rst_wr_n", wr_n, 1);
    chk("rst_s1s0", {s1, s0}, 0); chk("rst_hlda", hlda, 0); chk("rst_rdata", rdata, 0);
    rst = 0;
    tick(2);

    // memory read, zero wait
    clr_mon();
    req = 1; req_addr = 16'h12A4; ad_in = 8'h5C; ready = 1;
    tick(); req = 0; req_addr = 16'hFFFF;
    tick(6);
    chk("rd_ack_n", ack_cyc.size(), 1);
    chk("rd_rv_n", rv_cyc.size(), 1);
    chk("rd_ale_n", ale_cyc.size(), 1);
    chk("rd_low", rd_low, 2);
    if (ack_cyc.size() == 1 && rv_cyc.size() == 1) begin
      chk("rd_latency", rv_cyc[0] - ack_cyc[0], 4);
      chk("rd_data", rv_data[0], 8'h5C);
    end
    if (ale_cyc.size() == 1) begin
      chk("rd_ad_lo", ale_lo[0], 8'hA4); chk("rd_hi", ale_hi[0], 8'h12);
      chk("rd_st", ale_st[0], 2'b10); chk("rd_io", ale_io[0], 0);
    end

    // I/O write, three wait states (the last one ready, right at the timer limit)
    clr_mon();
    req = 1; req_we = 1; req_io = 1; req_addr = 16'h0033; req_wdata = 8'hE7; ready = 0;
    tick(); req = 0;
    tick(4); ready = 1;
    tick(4);
    req_we = 0; req_io = 0;
    chk("wr_low", wr_low, 5);
    chk("wr_data", wr_good, 5);
    chk("wr_tmo_n", tmo_cyc.size(), 0);
    chk("wr_rv_n", rv_cyc.size(), 0);
    if (ale_cyc.size() == 1) begin
      chk("wr_ad_lo", ale_lo[0], 8'h33); chk("wr_hi", ale_hi[0], 8'h00);
      chk("wr_st", ale_st[0], 2'b01); chk("wr_io", ale_io[0], 1);
    end else chk("wr_ale_n", ale_cyc.size(), 1);

    // timeout with ready stuck low
    clr_mon();
    req = 1; req_addr = 16'h4000; ad_in = 8'h3C; ready = 0;
    tick(); req = 0;
    tick(10); ready = 1;
    chk("to_tmo_n", tmo_cyc.size(), 1);
    chk("to_rd_low", rd_low, 5);
    chk("to_rv_n", rv_cyc.size(), 1);
    if (tmo_cyc.size() == 1 && ack_cyc.size() == 1) chk("to_cycle", tmo_cyc[0] - ack_cyc[0], 6);
    if (rv_data.size() == 1) chk("to_data", rv_data[0], 8'h3C);

    // back-to-back fetch then read with req held
    clr_mon();
    req = 1; req_fetch = 1; req_addr = 16'h0100; ad_in = 8'h11;
    tick(); req_fetch = 0; req_addr = 16'h0200;
    tick(3); req = 0;
    tick(5);
    chk("b2b_ack_n", ack_cyc.size(), 2);
    chk("b2b_rv_n", rv_cyc.size(), 2);
    if (ack_cyc.size() == 2) chk("b2b_ack_gap", ack_cyc[1] - ack_cyc[0], 3);
    if (ale_cyc.size() == 2) begin
      chk("b2b_ale_gap", ale_cyc[1] - ale_cyc[0], 3);
      chk("b2b_st0", ale_st[0], 2'b11); chk("b2b_st1", ale_st[1], 2'b10);
      chk("b2b_hi0", ale_hi[0], 8'h01); chk("b2b_hi1", ale_hi[1], 8'h02);
    end else chk("b2b_ale_n", ale_cyc.size(), 2);

    // hold raised during T2: cycle finishes, then bus handed over
    clr_mon();
    req = 1; req_addr = 16'h5566; ad_in = 8'h99;
    tick(); req = 0;
    tick(); hold = 1;
    tick(2);
    chk("hd_hlda", hlda, 1); chk("hd_float", bus_float, 1); chk("hd_oe", ad_oe, 0);
    req = 1;
    tick(2);
    chk("hd_ack_n", ack_cyc.size(), 1);
    chk("hd_rv_n", rv_cyc.size(), 1);
    hold = 0;
    tick();
    chk("hd_idle_hlda", hlda, 0);
    tick();
    chk("hd_t1", ale, 1);
    req = 0;
    tick(4);
    chk("hd_ack_n2", ack_cyc.size(), 2);

    // hold and req together in IDLE: hold first
    clr_mon();
    hold = 1; req = 1; req_addr = 16'h0A0B;
    tick();
    chk("hr_hlda", hlda, 1);
    tick(); hold = 0;
    tick();
    chk("hr_ack_n", ack_cyc.size(), 0);
    chk("hr_idle_hlda", hlda, 0);
    tick();
    chk("hr_t1", ale, 1);
    req = 0;
    tick(4);
    chk("hr_ack_n2", ack_cyc.size(), 1);

    // reset during a wait state
    clr_mon();
    req = 1; req_addr = 16'h7788; ready = 0;
    tick(); req = 0;
    tick(3);
    chk("rs_pre_rd_n", rd_n, 0);
    #2 rst = 1;
    #1;
    chk("rs_ale", ale, 0); chk("rs_rd_n", rd_n, 1); chk("rs_oe", ad_oe, 0);
    chk("rs_s1s0", {s1, s0}, 0); chk("rs_hi", haddress, 0); chk("rs_rdata", rdata, 0);
    tick(); rst = 0; ready = 1;
    tick(6);
    chk("rs_rv_n", rv_cyc.size(), 0);
    chk("rs_ack_n", ack_cyc.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
